// File: rtl/wall_follower_ctrl.sv
// Wall-following drive controller: debounced head/left sensors feed a
// search/follow/rotate policy with rotation timeout, timed back-off and turn telemetry.
module wall_follower_ctrl #(
    parameter int DEB_LEN     = 4,
    parameter int ROT_LIMIT   = 16,
    parameter int BACK_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_count,
    input  logic             head,
    input  logic             left,
    output logic             front,
    output logic             rotate,
    output logic             back,
    output logic [1:0]       state,
    output logic             stuck,
    output logic [CNT_W-1:0] turn_count
);

    localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int RW = $clog2(ROT_LIMIT);
    localparam int BW = (BACK_CYCLES > 1) ? $clog2(BACK_CYCLES) : 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        FOLLOW  = 2'b01,
        ROTATE  = 2'b10,
        BACKOFF = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_FRONT,
        CMD_ROTATE,
        CMD_BACK
    } cmd_t;

    state_t         state_q, state_nxt;
    cmd_t           cmd_nxt;
    logic [RW-1:0]  rot_cnt;
    logic [BW-1:0]  bk_cnt;
    logic [1:0]     raw;
    logic [1:0]     filt;
    logic [DW-1:0]  deb_cnt [2];

    // Bit 1 is head, bit 0 is left, so filt reads directly as the {head,left} table index.
    assign raw   = {head, left};
    assign state = state_q;

    // NOTE: the two debounce counters are a tiny register array, so resetting them
    // costs nothing; large memories would normally be left out of the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_LEN - 1)) begin
                    filt[i]    <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state_q;
        cmd_nxt   = CMD_NONE;
        unique case (state_q)
            SEARCH: begin
                case (filt)
                    2'b00:   begin state_nxt = SEARCH; cmd_nxt = CMD_FRONT;  end
                    2'b01:   begin state_nxt = FOLLOW; cmd_nxt = CMD_FRONT;  end
                    default: begin state_nxt = ROTATE; cmd_nxt = CMD_ROTATE; end
                endcase
            end
            FOLLOW: begin
                case (filt)
                    2'b01:   begin state_nxt = FOLLOW; cmd_nxt = CMD_FRONT;  end
                    2'b11:   begin state_nxt = ROTATE; cmd_nxt = CMD_ROTATE; end
                    default: begin state_nxt = SEARCH; cmd_nxt = CMD_ROTATE; end
                endcase
            end
            ROTATE: begin
                if (filt == 2'b01) begin
                    state_nxt = FOLLOW;
                    cmd_nxt   = CMD_FRONT;
                end else if (rot_cnt == RW'(ROT_LIMIT - 1)) begin
                    state_nxt = BACKOFF;
                    cmd_nxt   = CMD_BACK;
                end else begin
                    state_nxt = ROTATE;
                    cmd_nxt   = CMD_ROTATE;
                end
            end
            BACKOFF: begin
                if (bk_cnt == BW'(BACK_CYCLES - 1)) begin
                    state_nxt = SEARCH;
                    cmd_nxt   = CMD_FRONT;
                end else begin
                    state_nxt = BACKOFF;
                    cmd_nxt   = CMD_BACK;
                end
            end
            default: begin
                state_nxt = SEARCH;
                cmd_nxt   = CMD_NONE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            rot_cnt <= '0;
            bk_cnt  <= '0;
            front   <= 1'b0;
            rotate  <= 1'b0;
            back    <= 1'b0;
            stuck   <= 1'b0;
        end else if (en) begin
            state_q <= state_nxt;
            rot_cnt <= (state_q == ROTATE  && state_nxt == ROTATE)  ? rot_cnt + RW'(1) : '0;
            bk_cnt  <= (state_q == BACKOFF && state_nxt == BACKOFF) ? bk_cnt + BW'(1)  : '0;
            front   <= (cmd_nxt == CMD_FRONT);
            rotate  <= (cmd_nxt == CMD_ROTATE);
            back    <= (cmd_nxt == CMD_BACK);
            stuck   <= (state_nxt == BACKOFF) && (state_q != BACKOFF);
        end else begin
            front  <= 1'b0;
            rotate <= 1'b0;
            back   <= 1'b0;
            stuck  <= 1'b0;
        end
    end

    // Only entries from SEARCH/FOLLOW count; the clear works even while halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_count <= '0;
        end else if (clr_count) begin
            turn_count <= '0;
        end else if (en && (state_q == SEARCH || state_q == FOLLOW) &&
                     state_nxt == ROTATE && turn_count != '1) begin
            turn_count <= turn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Scoreboard bench for wall_follower_ctrl: a table-driven reference model predicts each
// cycle's outputs into a queue, and an independent monitor pops and compares.
module tb_wall_follower_ctrl;

    localparam int DEB_LEN     = 2;
    localparam int ROT_LIMIT   = 4;
    localparam int BACK_CYCLES = 2;
    localparam int CNT_W       = 2;
    localparam int TC_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             clr_count = 1'b0;
    logic             head = 1'b0;
    logic             left = 1'b0;
    logic             front, rotate, back, stuck;
    logic [1:0]       state;
    logic [CNT_W-1:0] turn_count;

    wall_follower_ctrl #(
        .DEB_LEN(DEB_LEN), .ROT_LIMIT(ROT_LIMIT),
        .BACK_CYCLES(BACK_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_count(clr_count),
        .head(head), .left(left), .front(front), .rotate(rotate),
        .back(back), .state(state), .stuck(stuck), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       st;
        logic             fr;
        logic             ro;
        logic             bk;
        logic             stk;
        logic [CNT_W-1:0] tc;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: states 0..3 = SEARCH/FOLLOW/ROTATE/BACKOFF, sensor index = {head,left}.
    int    next_tbl [3][4] = '{'{0, 1, 2, 2}, '{0, 1, 0, 2}, '{2, 1, 2, 2}};
    string cmd_tbl  [3]    = '{"FFRR", "RFRR", "RFRR"};
    int    m_st, m_dwell, m_tc;
    int    m_f   [2];
    int    m_run [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_dwell = 0; m_tc = 0;
        for (int i = 0; i < 2; i++) begin m_f[i] = 0; m_run[i] = 0; end
    endfunction

    function automatic obs_t model_step(input logic h, input logic l, input logic e, input logic c);
        obs_t o;
        byte  cmd;
        int   nst;
        int   sens;
        int   rawv;
        o   = '0;
        cmd = "-";
        if (c) m_tc = 0;
        if (e) begin
            sens = m_f[0] * 2 + m_f[1];
            if (m_st == 3) begin
                nst = (m_dwell == BACK_CYCLES - 1) ? 0 : 3;
                cmd = (nst == 0) ? "F" : "B";
            end else begin
                nst = next_tbl[m_st][sens];
                cmd = cmd_tbl[m_st][sens];
                if (m_st == 2 && nst == 2 && m_dwell == ROT_LIMIT - 1) begin
                    nst = 3;
                    cmd = "B";
                end
            end
            o.stk = (nst == 3 && m_st != 3);
            if (!c && m_st < 2 && nst == 2 && m_tc < TC_MAX) m_tc++;
            m_dwell = (nst == m_st) ? m_dwell + 1 : 0;
            m_st    = nst;
            o.fr = (cmd == "F");
            o.ro = (cmd == "R");
            o.bk = (cmd == "B");
        end
        o.st = m_st[1:0];
        o.tc = m_tc[CNT_W-1:0];
        for (int i = 0; i < 2; i++) begin
            rawv = (i == 0) ? int'(h) : int'(l);
            if (rawv != m_f[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB_LEN) begin m_f[i] = rawv; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
        end
        return o;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic h, input logic l, input logic e, input logic c);
        head = h; left = l; en = e; clr_count = c;
        exp_q.push_back(model_step(h, l, e, c));
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset", {state, front, rotate, back, stuck, turn_count}, '0);
        model_reset();
        head = 1'b0; left = 1'b0; en = 1'b0; clr_count = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    obs_t mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {state, front, rotate, back, stuck, turn_count};
                check($sformatf("cyc%0d", cyc), mon_act, mon_exp);
            end
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    int entries, prev, r_hold;
    logic r_h, r_l;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", {state, front, rotate, back, stuck, turn_count}, '0);
        rst_n = 1'b1;

        cycle(0, 0, 1, 0);
        check("first_edge", {state, front, rotate, back, stuck}, 6'b00_1000);
        repeat (8) cycle(0, 0, 1, 0);
        cycle(0, 1, 1, 0);
        repeat (4) cycle(0, 0, 1, 0);
        check("pulse_ignored", state, 2'b00);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        check("no_early_follow", state, 2'b00);
        cycle(0, 1, 1, 0);
        check("follow_state", state, 2'b01);
        check("follow_front", front, 1'b1);

        do_reset();
        repeat (3) cycle(1, 0, 1, 0);
        check("rot_state", state, 2'b10);
        check("rot_cmd", rotate, 1'b1);
        check("rot_count", turn_count, 1);
        repeat (3) cycle(1, 0, 1, 0);
        check("rot_dwell", state, 2'b10);
        cycle(1, 0, 1, 0);
        check("timeout_state", {state, back, stuck}, 4'b11_11);
        cycle(1, 0, 1, 0);
        check("backoff_hold", {state, back, stuck}, 4'b11_10);
        cycle(1, 0, 1, 0);
        check("backoff_exit", {state, front}, 3'b00_1);

        do_reset();
        repeat (4) cycle(1, 0, 1, 0);
        repeat (3) cycle(0, 1, 1, 0);
        check("late_follow", {state, front, stuck}, 4'b01_10);

        do_reset();
        entries = 0;
        for (int i = 0; i < 80 && entries < 5; i++) begin
            prev = m_st;
            cycle(1, 0, 1, 0);
            if (m_st == 2 && prev != 2) entries++;
        end
        check("saturate", turn_count, TC_MAX);
        for (int i = 0; i < 40 && !(m_st == 0 && m_f[0] == 1); i++) cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 1);
        check("clr_wins", {state, turn_count}, {2'b10, 2'b00});

        for (int i = 0; i < 40 && m_st != 3; i++) cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        repeat (5) begin
            cycle(1, 0, 0, 0);
            check("halt_backoff", {state, front, rotate, back, stuck}, 6'b11_0000);
        end
        cycle(1, 0, 1, 0);
        check("resume_exit", {state, front}, 3'b00_1);
        cycle(1, 0, 1, 0);
        check("reenter_rot", state, 2'b10);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                r_h    = 1'($urandom_range(0, 1));
                r_l    = 1'($urandom_range(0, 1));
                r_hold = $urandom_range(1, 8);
                for (int k = 0; k < r_hold; k++)
                    cycle(r_h, r_l, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
            end
        end

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wall_follower_ctrl.md
# wall_follower_ctrl

Parametrised wall-following controller for the robot's drive logic. It runs the three-state search/follow/rotate policy on debounced head and left contact sensors, and drives registered front/rotate/back motor commands. Over the single-bit Mealy controller it adds:
- per-sensor debounce
- a rotation timeout that forces a timed back-off manoeuvre
- an enable input
- a saturating turn counter for telemetry

## Interface
- DEB_LEN, 4: consecutive disagreeing cycles before a filtered sensor changes (≥1)
- ROT_LIMIT, 16: maximum consecutive cycles in ROTATE before timeout (≥2)
- BACK_CYCLES, 4: cycles spent in BACKOFF (≥1)
- CNT_W, 8: turn_count width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low = halt motors and freeze policy
- clr_count  in  1  synchronous clear of turn_count
- head  in  1  front contact sensor, synchronous to clk
- left  in  1  left wall sensor, synchronous to clk
- front  out  1  drive forward (registered)
- rotate  out  1  rotate right (registered)
- back  out  1  drive backward (registered)
- state  out  2  00 SEARCH, 01 FOLLOW, 10 ROTATE, 11 BACKOFF
- stuck  out  1  one-cycle pulse on entry to BACKOFF
- turn_count  out  CNT_W  entries into ROTATE, saturating

## Operation
- **Debounce, per sensor.** Filtered bit f with counter c.
  - When raw == f, c resets to 0.
  - When raw != f and c == DEB_LEN-1, f takes raw and c resets to 0.
  - Otherwise c increments.
  - Debounce runs regardless of en.
- **Policy table, on filtered {head,left}.** Each entry gives next state / command (F = front, R = rotate).
  - SEARCH: 00→SEARCH/F; 01→FOLLOW/F; 10,11→ROTATE/R.
  - FOLLOW: 00→SEARCH/R; 01→FOLLOW/F; 10→SEARCH/R; 11→ROTATE/R.
  - ROTATE: 01→FOLLOW/F; 00,10,11→ROTATE/R.
- **Rotation timeout.**
  - rot_cnt is 0 whenever state != ROTATE and increments each enabled cycle in ROTATE.
  - If state == ROTATE, the table gives ROTATE, and rot_cnt == ROT_LIMIT-1, the next state is BACKOFF instead.
  - A table exit to FOLLOW always wins over timeout.
- **BACKOFF.**
  - Command is back=1, front=0, rotate=0, independent of sensors.
  - bk_cnt counts BACK_CYCLES enabled cycles, then the next state is SEARCH with command F.
- **Command outputs.** front/rotate/back are registered from the table entry selected at the same edge as the state update. At most one command is high.
- **stuck.** Registered; high for exactly the one cycle after the edge that enters BACKOFF.
- **turn_count.**
  - Increments on each edge where state goes from SEARCH or FOLLOW to ROTATE.
  - Saturates at 2^CNT_W-1.
  - clr_count has priority over increment.
  - The ROTATE→BACKOFF edge does not count; BACKOFF→ROTATE is impossible.
- **en low.**
  - At each edge: state, rot_cnt, bk_cnt hold; front/rotate/back/stuck register 0.
  - turn_count still honours clr_count.
  - When en returns high, the next edge evaluates the table from the held state.

## Timing
- Reset (asynchronous assert, release synchronous to clk edge): state=SEARCH; front=rotate=back=stuck=0; turn_count=0; filtered sensors=0; all counters 0.
- First enabled edge after reset with sensors 00 drives front=1.
- Latency from a raw sensor change held stable to the command change is DEB_LEN+1 edges:
  - f updates at the DEB_LEN-th edge.
  - state and commands update at the next edge.
- Raw glitches shorter than DEB_LEN cycles never reach f.
- ROTATE dwell is at most ROT_LIMIT cycles.
- BACKOFF dwell is exactly BACK_CYCLES enabled cycles.
- Reset mid-BACKOFF or mid-ROTATE returns to SEARCH immediately; counters clear and no stuck pulse occurs.
- Simultaneous timeout and en low: en low wins; the timeout fires on the next enabled edge if the table still yields ROTATE.

## Test plan
All scenarios use DEB_LEN=2, ROT_LIMIT=4, BACK_CYCLES=2, CNT_W=2.
- Reset, en=1, sensors 00 -> after the first edge state=00, front=1, all else 0.
- left raised at cycle 10, held -> state=01 and front=1 from the 3rd edge after, never earlier; a 1-cycle left pulse produces no change.
- head=1 held from SEARCH -> state=10, rotate=1, turn_count=1; after 4 cycles in ROTATE -> state=11, back=1, stuck=1 for one cycle; 2 cycles later state=00, front=1.
- In ROTATE with rot_cnt=3, filtered {head,left}=01 -> state=01, front=1, no stuck.
- Five SEARCH→ROTATE entries -> turn_count=3 (saturated); clr_count pulsed together with a sixth entry -> turn_count=0.
- en=0 during BACKOFF for 5 cycles -> outputs 0, state stays 11; en=1 -> completes the remaining back cycle, then SEARCH. rst_n low mid-ROTATE -> all outputs 0 asynchronously.
